// File: rtl/i2c_target_responder.sv
`timescale 1ns/1ps
// i2c_target_responder
//   I2C target endpoint. SCL and SDA are oversampled with the system clock.
//   The block detects START and STOP, answers a 7-bit address, and ACKs the
//   address. Written bytes are delivered on a valid/ready byte port. Bytes
//   for reads are fetched from the user with a request strobe. The block
//   never stretches SCL.
//
//   Ports:
//     clk        system clock (100 MHz)
//     reset      asynchronous, active-low reset
//     scl        bus clock from the master (input only)
//     sda        open-drain data; driven only as 1'b0 or 1'bz
//     rx_data    last written byte
//     rx_valid   1-clk pulse when rx_data is updated
//     rx_first   qualifies rx_valid: first data byte since START
//     rx_ready   user can take a byte; sampled at the 8th SCL rise of a byte
//     tx_data    read byte; captured in the cycle tx_req is high
//     tx_req     1-clk pulse requesting the next read byte
//     busy       high from address match until STOP, mismatch or read NACK
//     start_det  1-clk pulse on START or repeated START
//     stop_det   1-clk pulse on STOP
//
//   Build option:
//     GLITCH_FILTER_EN  adds a 3-sample majority filter after the
//                       synchronisers. It rejects 1-clk pulses and adds
//                       2 clk of latency.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, WR_NACK, RD_BYTE, RD_ACK
  } state_t;

  // Synchronisers reset high: an idle bus must not look like an edge.
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

  logic w_scl, w_sda;
`ifdef GLITCH_FILTER_EN
  logic [2:0] r_scl_flt, r_sda_flt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_flt <= '1;
      r_sda_flt <= '1;
    end else begin
      r_scl_flt <= {r_scl_flt[1:0], r_scl_sync[SYNC_STAGES-1]};
      r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[SYNC_STAGES-1]};
    end
  end
  assign w_scl = (r_scl_flt[0] & r_scl_flt[1]) | (r_scl_flt[0] & r_scl_flt[2]) |
                 (r_scl_flt[1] & r_scl_flt[2]);
  assign w_sda = (r_sda_flt[0] & r_sda_flt[1]) | (r_sda_flt[0] & r_sda_flt[2]) |
                 (r_sda_flt[1] & r_sda_flt[2]);
`else
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

  logic r_scl_d, r_sda_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & ~r_sda_d & w_sda;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_phase;  // second half of a two-fall step (ACK drive/release, last read bit)
  logic       r_rw;
  logic       r_first;
  logic       r_sda_low;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_rx_first, r_tx_req, r_busy, r_start_det, r_stop_det;

  // Byte as it stands including the bit sampled on this rise.
  logic [7:0] w_byte;
  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_phase     <= 1'b0;
      r_rw        <= 1'b0;
      r_first     <= 1'b0;
      r_sda_low   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      // A read byte is taken in the cycle tx_req is high. No SCL edge can
      // land here because SCL half-periods are far longer than one clk.
      if (r_tx_req) r_shift <= tx_data;

      if (w_start) begin
        r_start_det <= 1'b1;
        r_bitcnt    <= '0;
        r_phase     <= 1'b0;
        r_first     <= 1'b1;
        r_sda_low   <= 1'b0;
        r_state     <= ADDR;
      end else if (w_stop) begin
        r_stop_det <= 1'b1;
        r_sda_low  <= 1'b0;
        r_busy     <= 1'b0;
        r_phase    <= 1'b0;
        r_state    <= IDLE;
      end else begin
        case (r_state)
          IDLE: ;
          ADDR: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (w_byte[7:1] == TARGET_ADDR) begin
                r_busy  <= 1'b1;
                r_rw    <= w_byte[0];
                r_phase <= 1'b0;
                r_state <= ADDR_ACK;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end
          ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_low <= 1'b1;
              r_phase   <= 1'b1;
              if (r_rw) r_tx_req <= 1'b1;
            end else begin
              r_phase  <= 1'b0;
              r_bitcnt <= '0;
              if (r_rw) begin
                r_sda_low <= ~r_shift[7];  // MSB goes out on the ACK-release fall
                r_state   <= RD_BYTE;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= WR_BYTE;
              end
            end
          end
          WR_BYTE: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (rx_ready) begin
                r_rx_data  <= w_byte;
                r_rx_valid <= 1'b1;
                r_rx_first <= r_first;
                r_first    <= 1'b0;
                r_phase    <= 1'b0;
                r_state    <= WR_ACK;
              end else begin
                r_state <= WR_NACK;
              end
            end
          end
          WR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_low <= 1'b1;
              r_phase   <= 1'b1;
            end else begin
              r_sda_low <= 1'b0;
              r_phase   <= 1'b0;
              r_state   <= WR_BYTE;
            end
          end
          // SDA stays released through the ACK clock; only START/STOP leave.
          WR_NACK: ;
          RD_BYTE: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_phase <= 1'b1;
            end else if (w_scl_fall) begin
              if (r_phase) begin
                r_sda_low <= 1'b0;
                r_phase   <= 1'b0;
                r_state   <= RD_ACK;
              end else begin
                r_sda_low <= ~r_shift[6];
                r_shift   <= {r_shift[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_tx_req <= 1'b1;
                r_phase  <= 1'b1;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else if (w_scl_fall && r_phase) begin
              r_sda_low <= ~r_shift[7];
              r_phase   <= 1'b0;
              r_bitcnt  <= '0;
              r_state   <= RD_BYTE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_first  = r_rx_first;
  assign tx_req    = r_tx_req;
  assign busy      = r_busy;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_target_responder.sv
`timescale 1ns/1ps
module tb_i2c_target_responder;
  localparam int Q = 100;  // quarter SCL period, ns (10 clk)

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda_low;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_req, busy, start_det, stop_det;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target_responder #(.TARGET_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_req(tx_req),
    .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt, txreq_cnt, start_cnt, stop_cnt, dut_low_cnt;

  typedef struct packed {logic first; logic [7:0] data;} rx_exp_t;
  rx_exp_t rx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      int had;
      rx_exp_t e;
      rx_cnt++;
      had = rx_q.size();
      chk("rx_expected", 32'(had > 0), 32'd1);
      if (had > 0) begin
        e = rx_q.pop_front();
        chk("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, e});
      end
    end
    if (tx_req === 1'b1)    txreq_cnt++;
    if (start_det === 1'b1) start_cnt++;
    if (stop_det === 1'b1)  stop_cnt++;
    if (sda_bus === 1'b0 && !m_sda_low) dut_low_cnt++;
  end

  task automatic clr_cnt();
    rx_cnt = 0; txreq_cnt = 0; start_cnt = 0; stop_cnt = 0; dut_low_cnt = 0;
  endtask

  // START from idle or repeated START from SCL low.
  task automatic i2c_start();
    m_sda_low = 1'b0; #(Q);
    scl = 1'b1;       #(Q);
    m_sda_low = 1'b1; #(Q);
    scl = 1'b0;       #(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #(Q);
    scl = 1'b1;       #(Q);
    m_sda_low = 1'b0; #(2*Q);
  endtask

  task automatic wr_bit(input logic b);
    m_sda_low = ~b; #(Q);
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda_low = 1'b0; #(Q);
    scl = 1'b1;       #(Q);
    b = sda_bus;      #(Q);
    scl = 1'b0;       #(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack_n);
  endtask

  task automatic rd_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    reset = 1'b0; scl = 1'b1; m_sda_low = 1'b0; rx_ready = 1'b1; tx_data = 8'h00;
    clr_cnt();
    #100;
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_pulses", {26'd0, rx_valid, rx_first, tx_req, busy, start_det, stop_det}, 32'd0);
    chk("rst_sda", {31'd0, sda_bus}, 32'd1);
    reset = 1'b1;
    #(4*Q);

    // Write transfer
    clr_cnt();
    i2c_start();
    wr_byte(8'h78, a); chk("wr_addr_ack", {31'd0, a}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    rx_q.push_back('{1'b1, 8'h00});
    wr_byte(8'h00, a); chk("wr_d0_ack", {31'd0, a}, 32'd0);
    rx_q.push_back('{1'b0, 8'hAF});
    wr_byte(8'hAF, a); chk("wr_d1_ack", {31'd0, a}, 32'd0);
    i2c_stop();
    chk("wr_rx_cnt", rx_cnt, 2);
    chk("wr_q_empty", rx_q.size(), 0);
    chk("wr_start_cnt", start_cnt, 1);
    chk("wr_stop_cnt", stop_cnt, 1);
    chk("wr_busy_end", {31'd0, busy}, 32'd0);

    // Address mismatch
    clr_cnt();
    i2c_start();
    wr_byte(8'h7A, a); chk("mm_addr_nack", {31'd0, a}, 32'd1);
    chk("mm_busy", {31'd0, busy}, 32'd0);
    wr_byte(8'h55, a); chk("mm_d_nack", {31'd0, a}, 32'd1);
    i2c_stop();
    chk("mm_dut_low", dut_low_cnt, 0);
    chk("mm_rx_cnt", rx_cnt, 0);
    chk("mm_start_cnt", start_cnt, 1);
    chk("mm_stop_cnt", stop_cnt, 1);

    // Read transfer
    clr_cnt();
    tx_data = 8'hA5;
    i2c_start();
    wr_byte(8'h79, a); chk("rd_addr_ack", {31'd0, a}, 32'd0);
    rd_byte(d); chk("rd_b0", {24'd0, d}, 32'hA5);
    tx_data = 8'h3C;
    wr_bit(1'b0);
    chk("rd_busy_mid", {31'd0, busy}, 32'd1);
    rd_byte(d); chk("rd_b1", {24'd0, d}, 32'h3C);
    wr_bit(1'b1);
    chk("rd_busy_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    chk("rd_txreq_cnt", txreq_cnt, 2);
    chk("rd_rx_cnt", rx_cnt, 0);

    // Backpressure
    clr_cnt();
    rx_ready = 1'b0;
    i2c_start();
    wr_byte(8'h78, a); chk("bp_addr_ack", {31'd0, a}, 32'd0);
    wr_byte(8'h40, a); chk("bp_d_nack", {31'd0, a}, 32'd1);
    i2c_stop();
    chk("bp_rx_cnt", rx_cnt, 0);
    rx_ready = 1'b1;

    // Repeated START
    clr_cnt();
    tx_data = 8'h5A;
    i2c_start();
    wr_byte(8'h78, a); chk("rs_addr_ack", {31'd0, a}, 32'd0);
    rx_q.push_back('{1'b1, 8'h00});
    wr_byte(8'h00, a); chk("rs_d_ack", {31'd0, a}, 32'd0);
    i2c_start();
    wr_byte(8'h79, a); chk("rs_raddr_ack", {31'd0, a}, 32'd0);
    rd_byte(d); chk("rs_rd", {24'd0, d}, 32'h5A);
    wr_bit(1'b1);
    i2c_stop();
    chk("rs_start_cnt", start_cnt, 2);
    chk("rs_rx_cnt", rx_cnt, 1);
    chk("rs_txreq_cnt", txreq_cnt, 1);

    // Reset while the address ACK is driven
    clr_cnt();
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(1'(8'h78 >> i));
    m_sda_low = 1'b0;
    #1;
    chk("ra_ack_low", {31'd0, sda_bus}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ra_sda_rel", {31'd0, sda_bus}, 32'd1);
    chk("ra_outs", {26'd0, rx_valid, rx_first, tx_req, busy, start_det, stop_det}, 32'd0);
    scl = 1'b1;
    #(Q);
    reset = 1'b1;
    #(4*Q);
    i2c_start();
    wr_byte(8'h78, a); chk("ra_addr_ack", {31'd0, a}, 32'd0);
    i2c_stop();
    chk("ra_stop_cnt", stop_cnt, 1);

    #(4*Q);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
